button_cmd_queue: RTL and testbench
===================================

# button_cmd_queue

Input-side counterpart to the VGA output path in the top level. It conditions the five raw push buttons (BTNC, BTNU, BTND, BTNR, BTNL) into clean, one-shot direction commands and queues them for the game logic. Queued commands are presented on a valid/ready handshake. The block runs in the boardCLK domain and is instantiated in top beside clock_divider.

## Interface
- DEBOUNCE_CYCLES, default 1000000, is the number of cycles the synchronized input must hold a new level before it is accepted (10 ms at 100 MHz). Legal range is ≥ 2.
- FIFO_DEPTH, default 4, is the number of queued commands. It must be a power of two.
- boardCLK  in  1  is the single clock for all state.
- resetN  in  1  is a synchronous, active-low reset, sampled on the rising edge of boardCLK.
- BTNC, BTNU, BTND, BTNR, BTNL  in  1 each  are the raw, asynchronous, bouncing button levels.
- cmdValid  out  1  is high while the queue is non-empty.
- cmdCode  out  3  is the command at the head of the queue: 1=UP, 2=DOWN, 3=LEFT, 4=RIGHT, 5=CENTER. It reads 0 when the queue is empty.
- cmdReady  in  1  is the consumer's accept signal. A pop occurs on cmdValid && cmdReady.
- heldMask  out  5  holds the debounced levels in the order {C,U,D,L,R}, bit 4 = C.
- overflow  out  1  is a sticky flag marking a lost press. It is cleared only by reset.

## Operation
- **Synchronizer:** each button passes through a 2-flop synchronizer, giving sync.
- **Debounce, per button:**
  - While sync equals stable, the counter is held at 0.
  - While they differ, the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and they still differ, stable takes sync and the counter clears.
  - Any return of sync to stable before that point clears the counter. Bounces shorter than DEBOUNCE_CYCLES therefore never change stable.
- **Press event:** a 0→1 transition of stable. Releases generate no command.
- **Pending:**
  - A press event sets that button's pending bit.
  - If the bit is already set at the press event, overflow is set and the bit stays set, so one command is lost.
- **Arbiter:**
  - Each cycle, if the FIFO is not full, or a pop occurs in the same cycle, the arbiter pushes the code of the highest-priority pending button and clears that pending bit.
  - Priority is C > U > D > L > R.
  - At most one push per cycle.
- **FIFO:**
  - First-word-fall-through: cmdCode shows the head combinationally from the storage register.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits. Full/empty is decided by comparing the MSB plus the address bits.
  - Pointers wrap modulo 2·FIFO_DEPTH.
  - Push and pop in the same cycle is legal at any occupancy, including full, and leaves occupancy unchanged.
- **Back-pressure:** when the FIFO is full and there is no pop, presses accumulate in pending (one per button) and do not overflow until the same button is pressed again.
- **Reset values:**
  - Synchronizers, stable, counters, pending, pointers, overflow and heldMask are all 0.
  - cmdValid = 0 and cmdCode = 0.
  - Reset asserted mid-operation discards queued and pending commands on the next edge.

## Timing
- Raw level changes before edge k and then holds:
  - sync changes after edge k+1.
  - stable and heldMask change after edge k+1+DEBOUNCE_CYCLES.
  - pending is set after edge k+2+DEBOUNCE_CYCLES.
  - cmdValid rises after edge k+3+DEBOUNCE_CYCLES, if the FIFO was empty.
- Pop: cmdValid && cmdReady at edge p. The next entry, or cmdValid=0, is visible after edge p.
- Presses pending simultaneously enter the FIFO on consecutive cycles, in priority order.
- A button held through reset deassertion debounces from stable=0 and produces exactly one new command.

## Structure
- Shared package game_pkg holds:
  - CMD_NONE/UP/DOWN/LEFT/RIGHT/CENTER (3-bit localparams).
  - Button index constants BTN_C=4, BTN_U=3, BTN_D=2, BTN_L=1, BTN_R=0.
- Sub-module btn_debounce (synchronizer + counter + stable + press pulse) is parameterized by DEBOUNCE_CYCLES and instantiated five times.
- Arbiter and FIFO stay inline.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and FIFO_DEPTH=4.
- **Reset:** hold resetN=0 with buttons toggling → all outputs 0, cmdCode=0.
- **Clean press:** BTNU rises before edge 0 and holds, cmdReady=0 → cmdValid=1 and cmdCode=1 after edge 7. Pulse cmdReady → cmdValid=0 on the next cycle.
- **Bounce rejection:** BTNL toggles every 2 cycles for 20 cycles, then held 0 → no cmdValid and heldMask[1] stays 0. Then hold BTNL=1 → one command with code 3.
- **Priority:** BTNC and BTNR rise on the same edge, cmdReady=0 → queue holds 5 then 4, written on consecutive cycles. Two pops return 5, 4.
- **Full/overflow:** with cmdReady=0, press and release C, U, D, L, R → FIFO full (5,1,2,3) and R pending, overflow=0. Re-press R → overflow=1. Drain with cmdReady=1 → sequence 5,1,2,3,4, then cmdValid=0.
- **Reset mid-queue:** with 3 entries queued and BTND held, pulse resetN=0 for one cycle → cmdValid=0 next cycle. Then cmdCode=2 appears 7 cycles after reset release, exactly once.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants: command codes presented to the game logic and the
// bit position of each push button inside the five-bit button vectors.
package game_pkg;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_UP     = 3'd1;
    localparam logic [2:0] CMD_DOWN   = 3'd2;
    localparam logic [2:0] CMD_LEFT   = 3'd3;
    localparam logic [2:0] CMD_RIGHT  = 3'd4;
    localparam logic [2:0] CMD_CENTER = 3'd5;

    localparam int BTN_C    = 4;
    localparam int BTN_U    = 3;
    localparam int BTN_D    = 2;
    localparam int BTN_L    = 1;
    localparam int BTN_R    = 0;
    localparam int NUM_BTNS = 5;

    function automatic logic [2:0] btn_cmd(input int idx);
        case (idx)
            BTN_C:   return CMD_CENTER;
            BTN_U:   return CMD_UP;
            BTN_D:   return CMD_DOWN;
            BTN_L:   return CMD_LEFT;
            BTN_R:   return CMD_RIGHT;
            default: return CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchronizer, hold-time debounce counter, debounced
// level and a one-cycle pulse registered alongside a 0->1 change of that level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic stable,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    logic          sync;

    assign sync = sync_q[1];

    // Any cycle where sync agrees with stable restarts the hold window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            cnt    <= '0;
            stable <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            press  <= 1'b0;
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= sync;
                press  <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_cmd_queue.sv
// Turns the five board buttons into one-shot direction commands, arbitrated by
// fixed priority into a first-word-fall-through queue read over valid/ready.
module button_cmd_queue
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       boardCLK,
    input  logic       resetN,
    input  logic       BTNC,
    input  logic       BTNU,
    input  logic       BTND,
    input  logic       BTNR,
    input  logic       BTNL,
    output logic       cmdValid,
    output logic [2:0] cmdCode,
    input  logic       cmdReady,
    output logic [4:0] heldMask,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] stable;
    logic [NUM_BTNS-1:0] press;
    logic [NUM_BTNS-1:0] pending;
    logic [NUM_BTNS-1:0] pending_nxt;
    logic [NUM_BTNS-1:0] grant;
    logic [2:0]          sel_idx;
    logic                sel_valid;
    logic [2:0]          push_code;
    logic                push;
    logic                pop;
    logic                lost;
    logic                empty;
    logic                full;
    logic [AW:0]         wptr;
    logic [AW:0]         rptr;
    logic [2:0]          mem [FIFO_DEPTH];

    assign btn_raw  = {BTNC, BTNU, BTND, BTNL, BTNR};
    assign heldMask = stable;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (boardCLK),
            .rst_n (resetN),
            .btn   (btn_raw[i]),
            .stable(stable[i]),
            .press (press[i])
        );
    end

    // cmdValid/cmdReady: an entry transfers on every edge where both are high;
    // cmdValid and cmdCode depend only on queue contents, never on cmdReady.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign cmdValid = !empty;
    assign pop      = cmdValid && cmdReady;
    assign cmdCode  = empty ? CMD_NONE : mem[rptr[AW-1:0]];

    // Higher bit index wins, giving C > U > D > L > R.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 3'd0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (pending[i]) begin
                sel_valid = 1'b1;
                sel_idx   = 3'(i);
            end
        end
        push  = sel_valid && (!full || pop);
        grant = '0;
        if (push) begin
            grant[sel_idx] = 1'b1;
        end
        push_code   = btn_cmd(int'(sel_idx));
        pending_nxt = (pending & ~grant) | press;
        lost        = |(press & pending & ~grant);
    end

    always_ff @(posedge boardCLK) begin
        if (!resetN) begin
            pending  <= '0;
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (lost) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // A push while full is only allowed with a pop, so it overwrites the slot being read.
    always_ff @(posedge boardCLK) begin
        if (resetN && push) begin
            mem[wptr[AW-1:0]] <= push_code;
        end
    end

endmodule

// File: tb/tb_button_cmd_queue.sv
// Self-checking bench for button_cmd_queue: directed table, corner-case
// sequences, then random button/ready/reset traffic against a queue-based model.
module tb_button_cmd_queue;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn;
    logic       rdy;
    logic       valid;
    logic [2:0] code;
    logic [4:0] held;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    button_cmd_queue #(
        .DEBOUNCE_CYCLES(DEB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .boardCLK(clk),
        .resetN  (rst_n),
        .BTNC    (btn[4]),
        .BTNU    (btn[3]),
        .BTND    (btn[2]),
        .BTNR    (btn[0]),
        .BTNL    (btn[1]),
        .cmdValid(valid),
        .cmdCode (code),
        .cmdReady(rdy),
        .heldMask(held),
        .overflow(ovf)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: still running at %0t, limit 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    // Driver tasks: inputs change on the falling edge, outputs are read there too
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic [4:0] b, input logic rd, input int n);
        rst_n = r;
        btn   = b;
        rdy   = rd;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] c,
                             input logic [4:0] h, input logic o);
        check({tag, "_valid"}, 32'(valid), 32'(v));
        check({tag, "_code"},  32'(code),  32'(c));
        check({tag, "_held"},  32'(held),  32'(h));
        check({tag, "_ovf"},   32'(ovf),   32'(o));
    endtask

    task automatic press_release(input int idx);
        logic [4:0] b;
        b      = 5'b0;
        b[idx] = 1'b1;
        apply(1'b1, b, 1'b0, 8);
        apply(1'b1, 5'b0, 1'b0, 8);
    endtask

    // Reference model: debounce as "last DEB synchronized samples all differ
    // from the accepted level", pending as flags, queue as the scoreboard.
    logic [2:0] exp_q[$];
    logic [4:0] m_stable;
    logic [4:0] m_press;
    logic [4:0] m_pending;
    logic       m_ovf;
    logic       hist[5][$];

    function automatic logic [2:0] cmd_of(input int idx);
        case (idx)
            4:       return 3'd5;
            3:       return 3'd1;
            2:       return 3'd2;
            1:       return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_stable  = '0;
        m_press   = '0;
        m_pending = '0;
        m_ovf     = 1'b0;
        for (int b = 0; b < 5; b++) begin
            hist[b].delete();
            hist[b].push_back(1'b0);
            hist[b].push_back(1'b0);
        end
    endtask

    task automatic model_step(input logic r, input logic [4:0] raw, input logic rd);
        logic       do_pop;
        logic       do_push;
        logic       accept;
        int         g;
        logic [4:0] nxt_pend;
        logic [4:0] new_press;
        if (!r) begin
            model_reset();
            return;
        end
        do_pop = (exp_q.size() != 0) && rd;
        g = -1;
        for (int b = 0; b < 5; b++) begin
            if (m_pending[b]) g = b;
        end
        do_push  = (g >= 0) && ((exp_q.size() < DEPTH) || do_pop);
        nxt_pend = m_pending;
        if (do_push) nxt_pend[g] = 1'b0;
        for (int b = 0; b < 5; b++) begin
            if (m_press[b]) begin
                if (m_pending[b] && !(do_push && g == b)) m_ovf = 1'b1;
                nxt_pend[b] = 1'b1;
            end
        end
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(cmd_of(g));
        new_press = '0;
        for (int b = 0; b < 5; b++) begin
            hist[b].push_front(raw[b]);
            if (hist[b].size() > DEB + 2) void'(hist[b].pop_back());
            accept = (hist[b].size() == DEB + 2);
            for (int j = 0; j < DEB; j++) begin
                if (hist[b][2 + j] == m_stable[b]) accept = 1'b0;
            end
            if (accept) begin
                m_stable[b]  = ~m_stable[b];
                new_press[b] = m_stable[b];
            end
        end
        m_press   = new_press;
        m_pending = nxt_pend;
    endtask

    typedef struct {
        logic       r;
        logic [4:0] b;
        logic       rd;
        int         n;
        logic       v;
        logic [2:0] c;
        logic [4:0] h;
        logic       o;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [2:0] drain[5];
        logic [4:0] nb;
        logic       nr;
        logic       nrd;
        int         hold_left[5];

        rst_n = 1'b0;
        btn   = 5'b0;
        rdy   = 1'b0;

        // Reset with toggling buttons, clean UP press and pop, release, C+R priority
        vecs.push_back('{1'b0, 5'b11111, 1'b0, 2, 1'b0, 3'd0, 5'b00000, 1'b0});
        vecs.push_back('{1'b0, 5'b01010, 1'b0, 1, 1'b0, 3'd0, 5'b00000, 1'b0});
        vecs.push_back('{1'b0, 5'b10101, 1'b1, 1, 1'b0, 3'd0, 5'b00000, 1'b0});
        vecs.push_back('{1'b0, 5'b00000, 1'b0, 2, 1'b0, 3'd0, 5'b00000, 1'b0});
        vecs.push_back('{1'b1, 5'b01000, 1'b0, 7, 1'b0, 3'd0, 5'b01000, 1'b0});
        vecs.push_back('{1'b1, 5'b01000, 1'b0, 1, 1'b1, 3'd1, 5'b01000, 1'b0});
        vecs.push_back('{1'b1, 5'b01000, 1'b1, 1, 1'b0, 3'd0, 5'b01000, 1'b0});
        vecs.push_back('{1'b1, 5'b00000, 1'b0, 8, 1'b0, 3'd0, 5'b00000, 1'b0});
        vecs.push_back('{1'b1, 5'b10001, 1'b0, 8, 1'b1, 3'd5, 5'b10001, 1'b0});
        vecs.push_back('{1'b1, 5'b10001, 1'b0, 1, 1'b1, 3'd5, 5'b10001, 1'b0});
        vecs.push_back('{1'b1, 5'b10001, 1'b1, 1, 1'b1, 3'd4, 5'b10001, 1'b0});
        vecs.push_back('{1'b1, 5'b10001, 1'b1, 1, 1'b0, 3'd0, 5'b10001, 1'b0});
        vecs.push_back('{1'b1, 5'b00000, 1'b0, 8, 1'b0, 3'd0, 5'b00000, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].r, vecs[i].b, vecs[i].rd, vecs[i].n);
            check_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].c, vecs[i].h, vecs[i].o);
        end

        // Bounce on L shorter than the hold time, then a real L press
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, (i % 2 == 0) ? 5'b00010 : 5'b00000, 1'b0, 2);
            check("bounce_valid", 32'(valid), 32'(0));
            check("bounce_held", 32'(held), 32'(0));
        end
        apply(1'b1, 5'b00000, 1'b0, 8);
        check_out("bounce_quiet", 1'b0, 3'd0, 5'b00000, 1'b0);
        apply(1'b1, 5'b00010, 1'b0, 8);
        check_out("bounce_press", 1'b1, 3'd3, 5'b00010, 1'b0);
        apply(1'b1, 5'b00010, 1'b1, 1);
        check("bounce_pop_valid", 32'(valid), 32'(0));
        apply(1'b1, 5'b00000, 1'b0, 8);

        // Fill the queue, leave R pending, re-press R to overflow, then drain
        for (int i = 4; i >= 0; i--) press_release(i);
        check_out("full", 1'b1, 3'd5, 5'b00000, 1'b0);
        press_release(0);
        check_out("overflow", 1'b1, 3'd5, 5'b00000, 1'b1);
        drain = '{3'd5, 3'd1, 3'd2, 3'd3, 3'd4};
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drain%0d_valid", i), 32'(valid), 32'(1));
            check($sformatf("drain%0d_code", i), 32'(code), 32'(drain[i]));
            @(negedge clk);
        end
        check_out("drained", 1'b0, 3'd0, 5'b00000, 1'b1);

        // Reset with three queued entries while D stays held
        press_release(4);
        press_release(3);
        apply(1'b1, 5'b00100, 1'b0, 8);
        check_out("midq_before", 1'b1, 3'd5, 5'b00100, 1'b1);
        apply(1'b0, 5'b00100, 1'b0, 1);
        check_out("midq_reset", 1'b0, 3'd0, 5'b00000, 1'b0);
        apply(1'b1, 5'b00100, 1'b0, 7);
        check_out("midq_wait", 1'b0, 3'd0, 5'b00100, 1'b0);
        apply(1'b1, 5'b00100, 1'b0, 1);
        check_out("midq_cmd", 1'b1, 3'd2, 5'b00100, 1'b0);
        apply(1'b1, 5'b00100, 1'b1, 1);
        check("midq_pop_valid", 32'(valid), 32'(0));
        apply(1'b1, 5'b00100, 1'b0, 10);
        check("midq_once_valid", 32'(valid), 32'(0));
        apply(1'b1, 5'b00000, 1'b0, 8);

        // Random traffic against the model
        apply(1'b0, 5'b00000, 1'b0, 2);
        model_reset();
        for (int b = 0; b < 5; b++) hold_left[b] = 0;
        nb = 5'b0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            check("rand_valid", 32'(valid), 32'(exp_q.size() != 0));
            check("rand_code", 32'(code), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'(0));
            check("rand_held", 32'(held), 32'(m_stable));
            check("rand_ovf", 32'(ovf), 32'(m_ovf));
            for (int b = 0; b < 5; b++) begin
                if (hold_left[b] == 0) begin
                    nb[b]        = 1'($urandom_range(0, 1));
                    hold_left[b] = $urandom_range(1, 14);
                end else begin
                    hold_left[b]--;
                end
            end
            nr  = ($urandom_range(0, 799) != 0);
            nrd = ($urandom_range(0, 3) == 0);
            rst_n = nr;
            btn   = nb;
            rdy   = nrd;
            model_step(nr, nb, nrd);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
